// File: rtl/hyperbus_burst_scheduler.sv
// Arbitrates the single HyperBus burst port between refill reads and write-line flushes.
// Define HYPERBUS_FLUSH_TIMER_EN to add the coalescing-window timer flush.
`timescale 1ns / 1ps
module hyperbus_burst_scheduler #(
    parameter int unsigned BurstSize  = 128,
    parameter int unsigned CoalWindow = 100,
    parameter int unsigned AddrWidth  = 48
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_req_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic                 rd_gnt_o,
    input  logic                 rd_done_i,
    input  logic                 wr_word_i,
    input  logic [AddrWidth-1:0] wr_base_i,
    output logic                 wr_stall_o,
    input  logic                 flush_i,
    output logic                 flush_valid_o,
    output logic [AddrWidth-1:0] flush_addr_o,
    input  logic                 flush_ready_i,
    input  logic                 flush_done_i,
    output logic                 busy_o
);

    localparam int unsigned CntW = $clog2(BurstSize) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(BurstSize);

    if (BurstSize < 2 || (BurstSize & (BurstSize - 1)) != 0) begin : gen_bad_burst
        $error("BurstSize must be a power of two >= 2");
    end
    if (CoalWindow < 1) begin : gen_bad_window
        $error("CoalWindow must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StRdBusy, StFlReq, StFlBusy} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      fill_q, fill_d;
    logic                 force_q, force_d;
    logic                 last_rd_q, last_rd_d;
    logic                 rd_gnt_q, rd_gnt_d;
    logic                 flush_valid_q, flush_valid_d;
    logic [AddrWidth-1:0] flush_addr_q, flush_addr_d;
    logic                 busy_q;

    logic full, accept, conflict, expired, urgent, start_flush, start_read;

    assign full       = fill_q == FullCnt;
    assign wr_stall_o = full || state_q == StFlReq || state_q == StFlBusy;
    assign accept     = wr_word_i && !wr_stall_o;
    assign conflict   = rd_req_i && fill_q != '0 && rd_addr_i == wr_base_i;

    // An expired timer outranks a read only when the previous grant was also a read.
    assign urgent      = conflict || full || (force_q && fill_q != '0) || (expired && last_rd_q);
    assign start_flush = state_q == StIdle && (urgent || (expired && !rd_req_i));
    assign start_read  = state_q == StIdle && !urgent && rd_req_i;

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        force_d       = force_q;
        last_rd_d     = last_rd_q;
        rd_gnt_d      = 1'b0;
        flush_valid_d = flush_valid_q;
        flush_addr_d  = flush_addr_q;

        if (accept) begin
            fill_d = fill_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_flush) begin
                    state_d       = StFlReq;
                    flush_valid_d = 1'b1;
                    flush_addr_d  = wr_base_i;
                    last_rd_d     = 1'b0;
                end else if (start_read) begin
                    state_d   = StRdBusy;
                    rd_gnt_d  = 1'b1;
                    last_rd_d = 1'b1;
                end
                // A fence against an empty line has nothing to write back.
                if (force_q && fill_q == '0) begin
                    force_d = 1'b0;
                end
            end
            StRdBusy: begin
                if (rd_done_i) begin
                    state_d = StIdle;
                end
            end
            StFlReq: begin
                if (flush_ready_i) begin
                    state_d       = StFlBusy;
                    flush_valid_d = 1'b0;
                    force_d       = 1'b0;
                end
            end
            StFlBusy: begin
                if (flush_done_i) begin
                    state_d = StIdle;
                    fill_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            force_d = 1'b1;
        end
    end

`ifdef HYPERBUS_FLUSH_TIMER_EN
    localparam int unsigned TmrW = $clog2(CoalWindow + 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(CoalWindow);

    logic [TmrW-1:0] timer_q, timer_d;

    // Age counts from the cycle the first word lands, so follow the next fill level.
    always_comb begin
        timer_d = timer_q;
        if (fill_d == '0) begin
            timer_d = '0;
        end else if ((state_q == StIdle || state_q == StRdBusy) && timer_q != TmrMax) begin
            timer_d = timer_q + TmrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expired = timer_q == TmrMax;
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            fill_q        <= '0;
            force_q       <= 1'b0;
            last_rd_q     <= 1'b0;
            rd_gnt_q      <= 1'b0;
            flush_valid_q <= 1'b0;
            flush_addr_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            force_q       <= force_d;
            last_rd_q     <= last_rd_d;
            rd_gnt_q      <= rd_gnt_d;
            flush_valid_q <= flush_valid_d;
            flush_addr_q  <= flush_addr_d;
            busy_q        <= state_d != StIdle;
        end
    end

    assign rd_gnt_o      = rd_gnt_q;
    assign flush_valid_o = flush_valid_q;
    assign flush_addr_o  = flush_addr_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_hyperbus_burst_scheduler.sv
// Directed and randomized bench for hyperbus_burst_scheduler against a cycle-level
// behavioural model of the scheduling rules; timer checks follow HYPERBUS_FLUSH_TIMER_EN.
`timescale 1ns / 1ps
module tb_hyperbus_burst_scheduler;

    localparam int BS = 128;
    localparam int CW = 100;
    localparam int AW = 48;
`ifdef HYPERBUS_FLUSH_TIMER_EN
    localparam bit TimerOn = 1'b1;
`else
    localparam bit TimerOn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rd_req, rd_done, wr_word, flush, flush_ready, flush_done;
    logic [AW-1:0] rd_addr, wr_base;
    logic          rd_gnt, wr_stall, flush_valid, busy;
    logic [AW-1:0] flush_addr;

    hyperbus_burst_scheduler #(
        .BurstSize (BS),
        .CoalWindow(CW),
        .AddrWidth (AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_req_i     (rd_req),
        .rd_addr_i    (rd_addr),
        .rd_gnt_o     (rd_gnt),
        .rd_done_i    (rd_done),
        .wr_word_i    (wr_word),
        .wr_base_i    (wr_base),
        .wr_stall_o   (wr_stall),
        .flush_i      (flush),
        .flush_valid_o(flush_valid),
        .flush_addr_o (flush_addr),
        .flush_ready_i(flush_ready),
        .flush_done_i (flush_done),
        .busy_o       (busy)
    );

    // Behavioural model: which burst the port is doing, how full and how old the line is.
    typedef enum int {MIdle, MRead, MFlCmd, MFlWait} mphase_t;
    mphase_t       ph = MIdle;
    int            fill = 0;
    int            age = 0;
    bit            force_f = 1'b0;
    bit            last_rd = 1'b0;
    bit            m_gnt = 1'b0;
    logic [AW-1:0] m_fa = '0;

    int checks = 0;
    int errors = 0;
    bit rec = 1'b0;
    bit prev_fv = 1'b0;
    int order_code = 0;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit took, expired, aging, want_flush;
        if (rst) begin
            ph = MIdle; fill = 0; age = 0; force_f = 0; last_rd = 0; m_gnt = 0; m_fa = '0;
            return;
        end
        took    = wr_word && !((fill == BS) || ph == MFlCmd || ph == MFlWait);
        expired = TimerOn && fill != 0 && age >= CW;
        aging   = (ph == MIdle || ph == MRead);
        m_gnt   = 1'b0;
        case (ph)
            MIdle: begin
                want_flush = (rd_req && fill != 0 && rd_addr == wr_base) || fill == BS ||
                             (force_f && fill != 0) || (expired && last_rd) ||
                             (expired && !rd_req);
                if (want_flush) begin
                    ph = MFlCmd; m_fa = wr_base; last_rd = 0;
                end else if (rd_req) begin
                    ph = MRead; m_gnt = 1; last_rd = 1;
                end
                if (force_f && fill == 0) force_f = 0;
            end
            MRead:  if (rd_done) ph = MIdle;
            MFlCmd: if (flush_ready) begin ph = MFlWait; force_f = 0; end
            MFlWait: if (flush_done) begin ph = MIdle; fill = 0; age = 0; end
            default: ;
        endcase
        if (took) fill++;
        if (fill == 0) age = 0;
        else if (aging && age < CW) age++;
        if (flush) force_f = 1;
    endtask

    // One clock: advance the model with this cycle's inputs, then compare every output.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("rd_gnt", rd_gnt, m_gnt);
        chk("flush_valid", flush_valid, (ph == MFlCmd));
        chk("flush_addr", flush_addr, m_fa);
        chk("wr_stall", wr_stall, ((fill == BS) || ph == MFlCmd || ph == MFlWait));
        chk("busy", busy, (ph != MIdle));
        if (rec) begin
            if (rd_gnt === 1'b1) order_code = order_code * 10 + 1;
            if (flush_valid === 1'b1 && !prev_fv) order_code = order_code * 10 + 2;
        end
        prev_fv = (flush_valid === 1'b1);
    endtask

    initial begin
        rst = 1; rd_req = 0; rd_done = 0; wr_word = 0; flush = 0;
        flush_ready = 0; flush_done = 0; rd_addr = '0; wr_base = '0;
        cycle();
        cycle();
        chk("reset_gnt", rd_gnt, 0);
        chk("reset_fv", flush_valid, 0);
        chk("reset_addr", flush_addr, 0);
        chk("reset_stall", wr_stall, 0);
        chk("reset_busy", busy, 0);
        rst = 0;

        // Plain read
        rd_req = 1; rd_addr = 48'h1000;
        cycle();
        chk("read_gnt", rd_gnt, 1);
        chk("read_busy", busy, 1);
        rd_req = 0;
        repeat (3) cycle();
        chk("read_gnt_pulse", rd_gnt, 0);
        chk("read_busy_hold", busy, 1);
        rd_done = 1; cycle(); rd_done = 0;
        chk("read_busy_clear", busy, 0);

        // Full line
        wr_base = 48'h4000; wr_word = 1;
        for (int i = 0; i < BS; i++) begin
            chk("full_no_stall", wr_stall, 0);
            cycle();
        end
        wr_word = 0;
        chk("full_stall", wr_stall, 1);
        chk("full_fv_early", flush_valid, 0);
        cycle();
        chk("full_fv", flush_valid, 1);
        chk("full_addr", flush_addr, 48'h4000);
        repeat (5) begin
            cycle();
            chk("full_fv_hold", flush_valid, 1);
            chk("full_addr_hold", flush_addr, 48'h4000);
        end
        flush_ready = 1; cycle(); flush_ready = 0;
        chk("full_fv_drop", flush_valid, 0);
        chk("full_stall_busy", wr_stall, 1);
        cycle();
        flush_done = 1; cycle(); flush_done = 0;
        chk("full_stall_clear", wr_stall, 0);
        chk("full_busy_clear", busy, 0);

        // Read conflicting with the write line
        wr_base = 48'h8000; wr_word = 1;
        repeat (3) cycle();
        wr_word = 0;
        rd_req = 1; rd_addr = 48'h8000;
        cycle();
        chk("conf_fv", flush_valid, 1);
        chk("conf_addr", flush_addr, 48'h8000);
        chk("conf_no_gnt", rd_gnt, 0);
        flush_ready = 1; cycle(); flush_ready = 0;
        repeat (2) cycle();
        chk("conf_gnt_wait", rd_gnt, 0);
        flush_done = 1; cycle(); flush_done = 0;
        chk("conf_gnt_idle", rd_gnt, 0);
        cycle();
        chk("conf_gnt", rd_gnt, 1);
        rd_req = 0;
        cycle();
        rd_done = 1; cycle(); rd_done = 0;

        // Coalescing timer
        wr_base = 48'hA000; wr_word = 1; cycle(); wr_word = 0;
`ifdef HYPERBUS_FLUSH_TIMER_EN
        repeat (CW - 1) cycle();
        chk("timer_not_yet", flush_valid, 0);
        cycle();
        chk("timer_flush", flush_valid, 1);
        chk("timer_addr", flush_addr, 48'hA000);
        flush_ready = 1; cycle(); flush_ready = 0;
        flush_done = 1; cycle(); flush_done = 0;

        // Anti-starvation with a continuously held read request
        rec = 1; order_code = 0;
        wr_base = 48'hB000; wr_word = 1; rd_req = 1; rd_addr = 48'h2000;
        cycle();
        wr_word = 0;
        repeat (CW + 20) cycle();
        rd_done = 1; cycle(); rd_done = 0;
        for (int n = 0; n < 8 && flush_valid !== 1'b1; n++) cycle();
        chk("starve_fv_seen", flush_valid, 1);
        flush_ready = 1; cycle(); flush_ready = 0;
        flush_done = 1; cycle(); flush_done = 0;
        for (int n = 0; n < 8 && rd_gnt !== 1'b1; n++) cycle();
        chk("starve_gnt_seen", rd_gnt, 1);
        rec = 0; rd_req = 0;
        cycle();
        rd_done = 1; cycle(); rd_done = 0;
        chk("starve_order", order_code, 121);
`else
        repeat (1000) cycle();
        chk("no_timer_flush", flush_valid, 0);
        chk("no_timer_idle", busy, 0);
`endif

        // Reset while a flush command is pending, then a fence on an empty line
        wr_base = 48'hC000; wr_word = 1; repeat (2) cycle(); wr_word = 0;
        flush = 1; cycle(); flush = 0;
        cycle();
        chk("rst_pre_fv", flush_valid, 1);
        rst = 1; cycle(); rst = 0;
        chk("rst_fv", flush_valid, 0);
        chk("rst_addr", flush_addr, 0);
        chk("rst_gnt", rd_gnt, 0);
        chk("rst_stall", wr_stall, 0);
        chk("rst_busy", busy, 0);
        flush = 1; cycle(); flush = 0;
        repeat (10) begin
            cycle();
            chk("empty_fence", flush_valid, 0);
        end

        // Randomized traffic; the bench plays the downstream engines
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(999) == 0);
            if (!rd_req && $urandom_range(9) == 0) begin
                rd_req  = 1;
                rd_addr = ($urandom_range(1) == 1) ? wr_base : (48'($urandom_range(15)) << 12);
            end
            if (fill == 0 && $urandom_range(3) == 0) wr_base = 48'($urandom_range(15)) << 12;
            wr_word     = ($urandom_range(9) < 7);
            flush       = ($urandom_range(49) == 0);
            flush_ready = (ph == MFlCmd) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
            flush_done  = (ph == MFlWait) ? ($urandom_range(3) == 0) : ($urandom_range(29) == 0);
            rd_done     = (ph == MRead) ? ($urandom_range(3) == 0) : ($urandom_range(29) == 0);
            cycle();
            if (m_gnt) rd_req = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
